// File: rtl/dnn_layer_seq.sv
// Sequencer for one fully-connected layer pass: sweeps ss inputs for each of os outputs,
// drives MAC controls and weight address, and issues delayed dst_buf write strobes.
module dnn_layer_seq #(
    parameter int AW   = 12,
    parameter int WAW  = 16,
    parameter int PIPE = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           stop,
    input  logic [AW-1:0]  ss,
    input  logic [AW-1:0]  os,
    output logic           busy,
    output logic           done,
    output logic           exec,
    output logic [AW-1:0]  ia,
    output logic [WAW-1:0] wa,
    output logic           init,
    output logic           last,
    output logic           outr,
    output logic [AW-1:0]  oa
);

    typedef enum logic [1:0] {IDLE, EXEC, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ss_r_q, ss_r_d;
    logic [AW-1:0]   os_r_q, os_r_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            exec_q, exec_d;
    logic [AW-1:0]   ia_q, ia_d;
    logic [WAW-1:0]  wa_q, wa_d;
    logic            init_q, init_d;
    logic            last_q, last_d;
    logic [AW-1:0]   o_q, o_d;
    logic [PIPE-1:0] vld_q, vld_d;
    logic [AW-1:0]   oidx_q [PIPE];
    logic [AW-1:0]   oidx_d [PIPE];

    always_comb begin
        state_d = state_q;
        ss_r_d  = ss_r_q;
        os_r_d  = os_r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        exec_d  = 1'b0;
        ia_d    = ia_q;
        wa_d    = wa_q;
        init_d  = 1'b0;
        last_d  = 1'b0;
        o_d     = o_q;

        // Write delay line: an output's index travels with its last-element strobe
        vld_d[0]  = exec_q & last_q;
        oidx_d[0] = o_q;
        for (int k = 1; k < PIPE; k++) begin
            vld_d[k]  = vld_q[k-1];
            oidx_d[k] = oidx_q[k-1];
        end

        if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            vld_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        ss_r_d = ss;
                        os_r_d = os;
                        if ((ss != '0) && (os != '0)) begin
                            state_d = EXEC;
                            busy_d  = 1'b1;
                            exec_d  = 1'b1;
                            ia_d    = '0;
                            wa_d    = '0;
                            o_d     = '0;
                            init_d  = 1'b1;
                            last_d  = (ss == AW'(1));
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (last_q) begin
                        if (o_q == os_r_q - AW'(1)) begin
                            state_d = FLUSH;
                        end else begin
                            exec_d = 1'b1;
                            ia_d   = '0;
                            wa_d   = wa_q + WAW'(1);
                            o_d    = o_q + AW'(1);
                            init_d = 1'b1;
                            last_d = (ss_r_q == AW'(1));
                        end
                    end else begin
                        exec_d = 1'b1;
                        ia_d   = ia_q + AW'(1);
                        wa_d   = wa_q + WAW'(1);
                        last_d = (ia_q + AW'(1) == ss_r_q - AW'(1));
                    end
                end
                FLUSH: begin
                    // Finish in the cycle right after the final write strobe leaves the line
                    if (vld_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ss_r_q  <= '0;
            os_r_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exec_q  <= 1'b0;
            ia_q    <= '0;
            wa_q    <= '0;
            init_q  <= 1'b0;
            last_q  <= 1'b0;
            o_q     <= '0;
            vld_q   <= '0;
            for (int k = 0; k < PIPE; k++) oidx_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ss_r_q  <= ss_r_d;
            os_r_q  <= os_r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            exec_q  <= exec_d;
            ia_q    <= ia_d;
            wa_q    <= wa_d;
            init_q  <= init_d;
            last_q  <= last_d;
            o_q     <= o_d;
            vld_q   <= vld_d;
            for (int k = 0; k < PIPE; k++) oidx_q[k] <= oidx_d[k];
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign exec = exec_q;
    assign ia   = ia_q;
    assign wa   = wa_q;
    assign init = init_q;
    assign last = last_q;
    assign outr = vld_q[PIPE-1];
    assign oa   = oidx_q[PIPE-1];

endmodule

// File: tb/tb_dnn_layer_seq.sv
// Directed bench for dnn_layer_seq: cycle-indexed expectations for whole passes, plus
// zero-length runs, stop, run-while-busy and asynchronous reset mid-pass.
module tb_dnn_layer_seq;

    localparam int AW   = 12;
    // Narrow weight address so the wrap case fits in a short run
    localparam int WAW  = 12;
    localparam int PIPE = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           run = 1'b0;
    logic           stop = 1'b0;
    logic [AW-1:0]  ss = '0;
    logic [AW-1:0]  os = '0;
    logic           busy, done, exec, init, last, outr;
    logic [AW-1:0]  ia, oa;
    logic [WAW-1:0] wa;

    int vectors = 0;
    int miscompares = 0;

    dnn_layer_seq #(.AW(AW), .WAW(WAW), .PIPE(PIPE)) dut (
        .clk(clk), .reset(reset), .run(run), .stop(stop), .ss(ss), .os(os),
        .busy(busy), .done(done), .exec(exec), .ia(ia), .wa(wa),
        .init(init), .last(last), .outr(outr), .oa(oa)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs in cycle c after an accepted run of an s x n pass
    task automatic check_pass_cycle(input string name, input int c, input int s, input int n);
        int total = s * n;
        int k = c - 1;
        int m = c - PIPE;
        bit exp_exec = (c >= 1) && (c <= total);
        bit exp_outr = (m >= 1) && (m <= total) && (((m - 1) % s) == s - 1);
        string t = $sformatf("%s c%0d", name, c);
        check_output({t, " exec"}, exec, exp_exec);
        check_output({t, " outr"}, outr, exp_outr);
        check_output({t, " done"}, done, (c == total + PIPE + 1));
        check_output({t, " busy"}, busy, (c >= 1) && (c <= total + PIPE));
        if (exp_exec) begin
            check_output({t, " ia"}, ia, k % s);
            check_output({t, " wa"}, wa, k % (1 << WAW));
            check_output({t, " init"}, init, (k % s) == 0);
            check_output({t, " last"}, last, (k % s) == s - 1);
        end
        if (exp_outr) check_output({t, " oa"}, oa, (m - 1) / s);
    endtask

    task automatic apply_stimulus(input int s, input int n);
        ss  = AW'(s);
        os  = AW'(n);
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check_output({name, " exec"}, exec, 0);
        check_output({name, " outr"}, outr, 0);
        check_output({name, " busy"}, busy, 0);
        check_output({name, " done"}, done, 0);
    endtask

    initial begin
        int n_outr;
        $display("[TB] start");

        tick();
        tick();
        check_output("rst busy", busy, 0);
        check_output("rst done", done, 0);
        check_output("rst exec", exec, 0);
        check_output("rst outr", outr, 0);
        check_output("rst ia", ia, 0);
        check_output("rst wa", wa, 0);
        check_output("rst oa", oa, 0);
        reset = 1'b0;
        tick();

        // ss=3 os=2: six execs, writes at cycles 6 and 9, done at 10
        apply_stimulus(3, 2);
        for (int c = 1; c <= 13; c++) begin
            check_pass_cycle("p32", c, 3, 2);
            tick();
        end

        // ss=1: every element is both first and last, writes on consecutive cycles
        apply_stimulus(1, 4);
        for (int c = 1; c <= 10; c++) begin
            check_pass_cycle("p14", c, 1, 4);
            tick();
        end

        // zero-length run: done next cycle, nothing else
        apply_stimulus(0, 5);
        for (int c = 1; c <= 6; c++) begin
            check_output($sformatf("zero c%0d done", c), done, c == 1);
            check_output($sformatf("zero c%0d exec", c), exec, 0);
            check_output($sformatf("zero c%0d busy", c), busy, 0);
            check_output($sformatf("zero c%0d outr", c), outr, 0);
            tick();
        end

        // run and stop together in IDLE: nothing starts
        stop = 1'b1;
        apply_stimulus(2, 2);
        stop = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check_idle($sformatf("runstop c%0d", c));
            tick();
        end

        // stop after six execs of a 4x4 pass, then a fresh pass restarts at 0
        apply_stimulus(4, 4);
        for (int c = 1; c <= 6; c++) begin
            check_pass_cycle("p44", c, 4, 4);
            if (c == 6) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        for (int c = 7; c <= 12; c++) begin
            check_idle($sformatf("stopped c%0d", c));
            tick();
        end
        apply_stimulus(2, 2);
        for (int c = 1; c <= 10; c++) begin
            check_pass_cycle("restart", c, 2, 2);
            tick();
        end

        // run pulsed while busy must not restart the pass
        apply_stimulus(2, 3);
        for (int c = 1; c <= 13; c++) begin
            check_pass_cycle("rwb", c, 2, 3);
            if (c == 3) begin
                ss = AW'(1);
                os = AW'(1);
                run = 1'b1;
            end
            tick();
            run = 1'b0;
        end

        // asynchronous reset mid-pass
        apply_stimulus(3, 4);
        for (int c = 1; c <= 8; c++) begin
            check_pass_cycle("arst", c, 3, 4);
            if (c < 8) tick();
        end
        #2 reset = 1'b1;
        #1;
        check_output("arst now exec", exec, 0);
        check_output("arst now busy", busy, 0);
        check_output("arst now outr", outr, 0);
        check_output("arst now init", init, 0);
        check_output("arst now last", last, 0);
        check_output("arst now ia", ia, 0);
        check_output("arst now wa", wa, 0);
        check_output("arst now oa", oa, 0);
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_idle($sformatf("postrst c%0d", c));
            tick();
        end

        // long pass: wa wraps at 2^WAW while ia/oa keep counting normally
        apply_stimulus(210, 20);
        n_outr = 0;
        for (int c = 1; c <= 210 * 20 + PIPE + 3; c++) begin
            check_pass_cycle("wrap", c, 210, 20);
            if (outr === 1'b1) n_outr++;
            if (c == 4097) check_output("wrap wa0", wa, 0);
            tick();
        end
        check_output("wrap outr count", n_outr, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
